// File: rtl/perip_bus_arbiter.sv
// perip_bus_arbiter: round-robin, single-beat, fixed-latency arbiter for the 0xffff0000 peripheral bus.
// Define PERIP_ARB_DECERR_EN to answer out-of-window addresses with a one-cycle m_err/m_ack, without a bus access.
module perip_bus_arbiter #(
    parameter int          NM         = 2,
    parameter logic [31:0] PERIP_BASE = 32'hffff0000,
    parameter logic [31:0] PERIP_MASK = 32'hffff0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req,
    input  logic [NM-1:0]    m_we,
    input  logic [32*NM-1:0] m_addr,
    input  logic [32*NM-1:0] m_wdata,
    output logic [NM-1:0]    m_gnt,
    output logic [NM-1:0]    m_ack,
    output logic [NM-1:0]    m_err,
    output logic [31:0]      m_rdata,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    inout  wire  [31:0]      mem_data
);
`ifdef PERIP_ARB_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif
    localparam int PW = (NM > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q, win_q, win_d;
    logic          any_req_d, bad_d, we_q, drive_q, mem_we_q;
    logic [31:0]   addr_d, wdata_q, rdata_q, mem_addr_q;
    logic [NM-1:0] gnt_q, ack_q, err_q, win_oh_d;

    // Search starts just past the last served master, so it ends up with lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        win_d     = ptr_q;
        any_req_d = 1'b0;
        for (int i = 1; i <= NM; i++) begin
            idx = PW'((int'(ptr_q) + i) % NM);
            if (!any_req_d && m_req[idx]) begin
                win_d     = idx;
                any_req_d = 1'b1;
            end
        end
    end

    assign win_oh_d = NM'(1) << win_d;
    assign addr_d   = m_addr[32*int'(win_d) +: 32];
    assign bad_d    = DECERR_EN && ((addr_d & PERIP_MASK) != PERIP_BASE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(NM - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            drive_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_req_d) begin
                    win_q   <= win_d;
                    we_q    <= m_we[win_d];
                    wdata_q <= m_wdata[32*int'(win_d) +: 32];
                    gnt_q   <= win_oh_d;
                    if (bad_d) begin
                        ack_q   <= win_oh_d;
                        err_q   <= win_oh_d;
                        rdata_q <= '0;
                        state_q <= DATA;
                    end else begin
                        mem_we_q   <= m_we[win_d];
                        mem_addr_q <= addr_d;
                        drive_q    <= m_we[win_d];
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    rdata_q    <= we_q ? '0 : mem_data;
                    ack_q      <= gnt_q;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= '0;
                    drive_q    <= 1'b0;
                    state_q    <= DATA;
                end
                default: begin
                    ptr_q   <= win_q;
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    err_q   <= '0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_gnt    = gnt_q;
    assign m_ack    = ack_q;
    assign m_err    = err_q;
    assign m_rdata  = rdata_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = drive_q ? wdata_q : 32'bz;
endmodule
